// File: rtl/audio_sigmadelta_dac_pkg.sv
// Shared constants for the sigma-delta audio DAC: default widths and the
// dither LFSR polynomial/seed.
package audio_sigmadelta_dac_pkg;

  localparam int DW_DEFAULT        = 15;
  localparam int DIV_SHIFT_DEFAULT = 6;

  // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form shifting left.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/audio_sigmadelta_dac_sd_channel.sv
// One audio channel: linear interpolator between sample ticks followed by a
// first-order sigma-delta modulator producing a 1-bit stream.
module audio_sigmadelta_dac_sd_channel
  import audio_sigmadelta_dac_pkg::*;
#(
  parameter int DW        = DW_DEFAULT,
  parameter int DIV_SHIFT = DIV_SHIFT_DEFAULT,
  parameter int DITHER    = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic [DW-1:0] sample,
  input  logic [1:0]    dither,
  output logic          audio
);

  localparam int FW = DW + DIV_SHIFT + 1;

  logic [DW-1:0] target;
  logic [DW:0]   diff;
  logic [FW-1:0] frac;
  logic [DW-1:0] cur;
  logic [DW-1:0] u;
  logic [DW:0]   acc;
  logic [DW:0]   acc_sum;
  logic [1:0]    dither_eff;

  // frac holds cur scaled by 2**DIV_SHIFT; the tick snap makes the ramp
  // land exactly on target, so rounding error never accumulates.
  assign cur        = frac[DIV_SHIFT +: DW];
  assign u          = {~cur[DW-1], cur[DW-2:0]};
  assign dither_eff = (DITHER != 0) ? dither : 2'b00;
  assign acc_sum    = {1'b0, acc[DW-1:0]} + {1'b0, u} + {{(DW-1){1'b0}}, dither_eff};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target <= '0;
      diff   <= '0;
      frac   <= '0;
      acc    <= '0;
    end else begin
      if (tick) begin
        target <= sample;
        frac   <= {target[DW-1], target, {DIV_SHIFT{1'b0}}};
        diff   <= {sample[DW-1], sample} - {target[DW-1], target};
      end else begin
        frac   <= frac + {{DIV_SHIFT{diff[DW]}}, diff};
      end
      acc <= acc_sum;
    end
  end

  // The carry out of the accumulator is the registered bitstream.
  assign audio = acc[DW];

endmodule

// File: rtl/audio_sigmadelta_dac.sv
// Stereo sigma-delta DAC: sample tick generation, L/R swap and centred mix,
// dither LFSR, and one interpolating modulator per channel.
module audio_sigmadelta_dac
  import audio_sigmadelta_dac_pkg::*;
#(
  parameter int DW        = DW_DEFAULT,
  parameter int DIV_SHIFT = DIV_SHIFT_DEFAULT,
  parameter int DITHER    = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] ldata,
  input  logic [DW-1:0] rdata,
  input  logic          exchan,
  input  logic          mix,
  output logic          audio_left,
  output logic          audio_right,
  output logic          sample_tick
);

  logic [DIV_SHIFT-1:0] cnt;
  logic [15:0]          lfsr;
  logic [DW-1:0]        a;
  logic [DW-1:0]        b;
  logic [DW-1:0]        mix_l;
  logic [DW-1:0]        mix_r;
  logic [DW-1:0]        sel_l;
  logic [DW-1:0]        sel_r;

  assign a = exchan ? rdata : ldata;
  assign b = exchan ? ldata : rdata;

  // 3/4 own + 1/4 other: magnitudes sum to at most full scale, so no clip.
  assign mix_l = ($signed(a) >>> 1) + ($signed(a) >>> 2) + ($signed(b) >>> 2);
  assign mix_r = ($signed(b) >>> 1) + ($signed(b) >>> 2) + ($signed(a) >>> 2);

  assign sel_l = mix ? mix_l : a;
  assign sel_r = mix ? mix_r : b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      sample_tick <= 1'b0;
      lfsr        <= LFSR_SEED;
    end else begin
      cnt         <= cnt + 1'b1;
      sample_tick <= (cnt == '1);
      lfsr        <= lfsr_next(lfsr);
    end
  end

  audio_sigmadelta_dac_sd_channel #(
    .DW        (DW),
    .DIV_SHIFT (DIV_SHIFT),
    .DITHER    (DITHER)
  ) u_left (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick   (sample_tick),
    .sample (sel_l),
    .dither (lfsr[1:0]),
    .audio  (audio_left)
  );

  audio_sigmadelta_dac_sd_channel #(
    .DW        (DW),
    .DIV_SHIFT (DIV_SHIFT),
    .DITHER    (DITHER)
  ) u_right (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick   (sample_tick),
    .sample (sel_r),
    .dither (lfsr[3:2]),
    .audio  (audio_right)
  );

endmodule
